// File: rtl/sc_pkg.sv
// Shared definitions for the basic-computer sequence counter.
// Holds the sequencer state type, default sizing constants and the step-name
// constants T0_STEP..T7_STEP shared by the timing decoder and control logic.
package sc_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } sc_state_e;

  // Step names as they appear on the SC bus.
  localparam logic [3:0] T0_STEP = 4'd0;
  localparam logic [3:0] T1_STEP = 4'd1;
  localparam logic [3:0] T2_STEP = 4'd2;
  localparam logic [3:0] T3_STEP = 4'd3;
  localparam logic [3:0] T4_STEP = 4'd4;
  localparam logic [3:0] T5_STEP = 4'd5;
  localparam logic [3:0] T6_STEP = 4'd6;
  localparam logic [3:0] T7_STEP = 4'd7;

  localparam int unsigned ScWDef       = 4;
  localparam int unsigned LastStepDef  = 32'(T7_STEP);
  localparam int unsigned CntWDef      = 16;

endpackage

// File: rtl/sc_sequencer.sv
// Sequence-counter generator for the basic-computer control unit.
// Produces the step count SC (decoded downstream into T0..T7), with start/halt
// control, a memory stall, instruction-complete clearing and an instruction
// counter for bring-up.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      level; leave IDLE and begin at T0
//   halt_i       level; stop sequencing, return to IDLE
//   clr_i        instruction complete; SC returns to 0 next cycle
//   stall_i      hold current SC
//   sc_o         current step count
//   running_o    high while in RUN
//   wrap_o       one-cycle pulse when SC wraps LAST_STEP -> 0 without clr
//   instr_cnt_o  count of completed instructions (clr events, mod 2^CNT_W)
//   wrap_err_o   sticky wrap flag, present only when SC_WRAP_ERR_EN is defined
//
// Optional feature macro: SC_WRAP_ERR_EN.
module sc_sequencer
  import sc_pkg::*;
#(
  parameter int unsigned SC_W      = ScWDef,
  parameter int unsigned LAST_STEP = LastStepDef,
  parameter int unsigned CNT_W     = CntWDef
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             halt_i,
  input  logic             clr_i,
  input  logic             stall_i,
  output logic [SC_W-1:0]  sc_o,
  output logic             running_o,
  output logic             wrap_o,
`ifdef SC_WRAP_ERR_EN
  output logic             wrap_err_o,
`endif
  output logic [CNT_W-1:0] instr_cnt_o
);

  if (LAST_STEP >= (64'd1 << SC_W)) begin : g_bad_last_step
    $error("sc_sequencer: LAST_STEP does not fit in SC_W bits");
  end

  localparam logic [SC_W-1:0] LastStep = SC_W'(LAST_STEP);
  localparam logic [SC_W-1:0] FirstStep = SC_W'(T0_STEP);

  sc_state_e        state_q, state_d;
  logic [SC_W-1:0]  sc_q, sc_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    wrap_d  = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        sc_d = FirstStep;
        if (start_i) begin
          state_d = StRun;
        end
      end
      StRun: begin
        // halt > clr > stall > increment
        if (halt_i) begin
          state_d = StIdle;
          sc_d    = FirstStep;
          if (clr_i) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (clr_i) begin
          sc_d  = FirstStep;
          cnt_d = cnt_q + CNT_W'(1);
        end else if (stall_i) begin
          sc_d = sc_q;
        end else if (sc_q < LastStep) begin
          sc_d = sc_q + SC_W'(1);
        end else begin
          sc_d   = FirstStep;
          wrap_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        sc_d    = FirstStep;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      sc_q    <= FirstStep;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SC_WRAP_ERR_EN
  logic wrap_err_q, wrap_err_d;

  // Set together with the wrap pulse; a start accepted in IDLE clears it.
  always_comb begin
    wrap_err_d = wrap_err_q | wrap_d;
    if (state_q == StIdle && start_i) begin
      wrap_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrap_err_q <= 1'b0;
    end else begin
      wrap_err_q <= wrap_err_d;
    end
  end

  assign wrap_err_o = wrap_err_q;
`endif

  assign sc_o        = sc_q;
  assign running_o   = (state_q == StRun);
  assign wrap_o      = wrap_q;
  assign instr_cnt_o = cnt_q;

endmodule

// File: tb/tb_sc_sequencer.sv
// Scoreboard bench for sc_sequencer: a driver applies directed and random
// control patterns, pushes the reference model's expected outputs into a
// queue, and a monitor pops and compares once per cycle on the falling edge.
module tb_sc_sequencer;

  localparam int LAST = 7;
  localparam int CNT_MOD = 65536;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, halt = 1'b0, clr = 1'b0, stall = 1'b0;
  logic [3:0]  sc;
  logic        running, wrap;
  logic [15:0] instr_cnt;
`ifdef SC_WRAP_ERR_EN
  logic        wrap_err;
`endif

  sc_sequencer dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .halt_i      (halt),
    .clr_i       (clr),
    .stall_i     (stall),
    .sc_o        (sc),
    .running_o   (running),
    .wrap_o      (wrap),
`ifdef SC_WRAP_ERR_EN
    .wrap_err_o  (wrap_err),
`endif
    .instr_cnt_o (instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sc;
    int run;
    int wrap;
    int cnt;
    int werr;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state, kept as plain integers.
  int m_run, m_sc, m_cnt, m_wrap, m_werr;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    check("sc", int'(sc), e.sc);
    check("running", int'(running), e.run);
    check("wrap", int'(wrap), e.wrap);
    check("instr_cnt", int'(instr_cnt), e.cnt);
`ifdef SC_WRAP_ERR_EN
    check("wrap_err", int'(wrap_err), e.werr);
`endif
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.sc = m_sc; e.run = m_run; e.wrap = m_wrap; e.cnt = m_cnt; e.werr = m_werr;
    return e;
  endfunction

  function automatic void model_reset();
    m_run = 0; m_sc = 0; m_cnt = 0; m_wrap = 0; m_werr = 0;
  endfunction

  // One clock of behaviour from the control rules: halt beats clr beats stall.
  function automatic void model_step(input int st, input int h, input int c, input int s);
    m_wrap = 0;
    if (m_run == 0) begin
      if (st != 0) begin
        m_run = 1; m_sc = 0; m_werr = 0;
      end
    end else if (h != 0) begin
      m_run = 0; m_sc = 0;
      if (c != 0) m_cnt = (m_cnt + 1) % CNT_MOD;
    end else if (c != 0) begin
      m_sc = 0;
      m_cnt = (m_cnt + 1) % CNT_MOD;
    end else if (s == 0) begin
      m_sc = (m_sc + 1) % (LAST + 1);
      if (m_sc == 0) begin
        m_wrap = 1; m_werr = 1;
      end
    end
  endfunction

  // Drive from a falling edge, push expectation at the rising edge.
  task automatic cyc(input int st, input int h, input int c, input int s);
    start = st[0]; halt = h[0]; clr = c[0]; stall = s[0];
    model_step(st, h, c, s);
    @(posedge clk);
    exp_q.push_back(snapshot());
    @(negedge clk);
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 16 && m_sc != target; i++) cyc(0, 0, 0, 0);
    check("run_to_reached", m_sc, target);
  endtask

  task automatic ensure_run();
    if (m_run == 0) cyc(1, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) check_outputs(exp_q.pop_front());
  end

  initial begin
    exp_t e;
    model_reset();
    @(negedge clk);
    check_outputs(snapshot());
    rst_n = 1'b1;

    // Free run through all steps and one wrap.
    cyc(1, 0, 0, 0);
    repeat (9) cyc(0, 0, 0, 0);

    // clr at T3, then counting resumes.
    run_to(3);
    cyc(0, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 0);

    // Stall at T2 for four cycles, then clr+stall at T5.
    run_to(2);
    repeat (4) cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    run_to(5);
    cyc(0, 0, 1, 1);

    // halt+clr at T4, then idle-time controls are ignored.
    run_to(4);
    cyc(0, 1, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 1, 1);
    cyc(0, 0, 1, 0);

    // Restart (clears the sticky flag), then start while running is a no-op.
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);

    // Randomized control traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 5) == 0) ? 1 : 0,
          ($urandom_range(0, 15) == 0) ? 1 : 0,
          ($urandom_range(0, 7) == 0) ? 1 : 0,
          ($urandom_range(0, 3) == 0) ? 1 : 0);
    end

    // Drive instr_cnt to 0xFFFF with back-to-back clr, then roll over.
    ensure_run();
    for (int i = 0; i < CNT_MOD && m_cnt != CNT_MOD - 1; i++) cyc(0, 0, 1, 0);
    check("cnt_preload", m_cnt, CNT_MOD - 1);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);

    // Asynchronous reset mid-cycle at T6.
    run_to(6);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    e = snapshot();
    check_outputs(e);
    start = 1'b0; halt = 1'b0; clr = 1'b0; stall = 1'b0;
    @(negedge clk);
    check_outputs(e);
    rst_n = 1'b1;
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sc_sequencer.md
Name: sc_sequencer

Overview:
Sequence-counter generator for the basic-computer control unit. It produces the 4-bit step count SC that the downstream timing decoder expands into the one-hot T0..T7 strobes. It also provides start/halt control, a stall input for slow memory, instruction-complete clearing, and an instruction counter for bring-up and debug.

Parameters:
SC_W, 4, width of SC output.
LAST_STEP, 7, highest legal step; counting past it wraps to 0.
CNT_W, 16, width of instr_cnt.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  level; leave IDLE and begin sequencing at T0
halt  input  1  level; stop sequencing, return to IDLE
clr  input  1  instruction complete; SC returns to 0 next cycle
stall  input  1  hold current SC (memory not ready)
sc  output  SC_W  current step count to timing decoder
running  output  1  high while in RUN state
wrap  output  1  one-cycle pulse when SC wraps LAST_STEP->0 without clr
instr_cnt  output  CNT_W  count of completed instructions (clr events)

Behaviour:
- Clock/reset: single clock clk; reset rst_n is asynchronous, active-low. While rst_n=0: state=IDLE, sc=0, running=0, wrap=0, instr_cnt=0. Reset mid-instruction aborts immediately; no pending event survives it.
- FSM states: IDLE, RUN.
- IDLE:
  - sc held at 0, running=0, wrap=0.
  - start=1 -> RUN next cycle with sc=0.
  - clr, stall and halt are ignored in IDLE.
- RUN, evaluated each cycle in priority order halt > clr > stall > increment:
  - halt=1: next state IDLE, sc<=0. If clr=1 in the same cycle, instr_cnt still increments.
  - clr=1 (no halt): sc<=0, instr_cnt<=instr_cnt+1, stay in RUN. clr overrides stall.
  - stall=1 (no halt, no clr): sc holds, wrap=0.
  - Otherwise, if sc<LAST_STEP: sc<=sc+1.
  - Otherwise (sc==LAST_STEP): sc<=0 and wrap=1 for exactly the cycle in which sc shows 0. instr_cnt is not incremented on a wrap.
- running is registered; it equals (state==RUN) with no combinational path from inputs.
- start asserted while in RUN has no effect.
- Latency:
  - All outputs are registered.
  - A control input sampled at edge N is reflected in the outputs after edge N.
  - One cycle from start to the first T0 in RUN.
- Arithmetic: instr_cnt wraps modulo 2^CNT_W (0xFFFF -> 0x0000), with no flag. sc is never greater than LAST_STEP.
- Legality: LAST_STEP must be below 2^SC_W; elaboration fails otherwise.

Optional Feature:
SC_WRAP_ERR_EN
- Defined: adds output wrap_err (1 bit), a sticky flag.
  - Set on any cycle where wrap is asserted.
  - Cleared by rst_n=0, or by start=1 accepted in IDLE.
  - Reset value 0.
- Undefined: the wrap_err port and its logic are absent; wraps are signalled only by the wrap pulse.

Decomposition:
- Shared package sc_pkg:
  - state enum (IDLE, RUN)
  - default SC_W, LAST_STEP and CNT_W constants
  - step-name constants T0_STEP..T7_STEP, reused by the timing decoder and the control logic
- No sub-module. The instruction counter is a simple register inside sc_sequencer.

Test Plan:
- Reset then start=1 for one cycle, no other inputs -> running=1; sc steps 0,1,...,7, then 0 with wrap=1 for one cycle; instr_cnt stays 0.
- In RUN, assert clr when sc=3 -> sc=0 on the next cycle, instr_cnt=1, wrap=0; counting then resumes 1,2,...
- stall=1 for 4 cycles at sc=2, then release -> sc reads 2 for 4 cycles, then 3; clr+stall together at sc=5 -> sc=0, instr_cnt increments.
- halt+clr in the same cycle at sc=4 -> IDLE, sc=0, running=0, instr_cnt incremented; later clr pulses in IDLE are ignored.
- Preload instr_cnt to 0xFFFF via 65535 clr events (or force) then clr -> instr_cnt=0x0000; drop rst_n asynchronously mid-cycle at sc=6 -> all outputs 0 immediately.
- With SC_WRAP_ERR_EN: let sc wrap once -> wrap_err=1 and stays 1; halt, then start -> wrap_err=0.
